udm_uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver with an output frame FIFO. It is the next-generation receive front end for the UDM debug bridge in magma-class SoCs. Baud divider, data width (5-8), parity mode and stop-bit count are programmable, and parity, framing, break and overflow conditions are all reported. It sits between the top-level rx_i pin and the UDM command decoder, which consumes frames over a valid/ready interface.

---
 rtl/udm_uart_rx_cfg.sv | 269 ++++++++++++++++++++++++++
 tb/tb_udm_uart_rx_cfg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udm_uart_rx_cfg.sv
// udm_uart_rx_cfg: runtime-configurable UART receiver with an output frame FIFO.
//
// The receiver samples a synchronized copy of rx_i. It re-aligns to the middle of
// the start bit, and then samples every divider cycles. The divider, data width,
// parity mode and stop-bit count are captured when a start edge is seen. Each
// complete frame is pushed into a first-word-fall-through FIFO as
// {data, perr, ferr}.
//
// Ports:
//   clk_i, srst_n_i       clock, synchronous active-low reset
//   rx_i                  serial input, idle high
//   en_i                  receiver enable; dropping it mid-frame discards the frame
//   divider_i             clock cycles per bit (values below 4 act as 4)
//   nbits_i               data bits 5..8 (00..11)
//   parity_i              00/11 none, 01 even, 10 odd
//   stop2_i               two stop bits when 1
//   rdata_o/perr_o/ferr_o head frame (all zero while the FIFO is empty)
//   rvalid_o/rready_i     FIFO not empty / pop handshake
//   ovf_o/ovf_clr_i       sticky overflow flag and its clear
//   break_o               one-cycle pulse when a break frame is seen
//   busy_o                receiver is inside a frame
module udm_uart_rx_cfg #(
  parameter int unsigned DATA_MAX    = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DIV_WIDTH   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 srst_n_i,
  input  logic                 rx_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic [1:0]           nbits_i,
  input  logic [1:0]           parity_i,
  input  logic                 stop2_i,
  output logic [DATA_MAX-1:0]  rdata_o,
  output logic                 perr_o,
  output logic                 ferr_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int unsigned BW = $clog2(DATA_MAX + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_MAX + 2;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           nbits_q, nbits_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_MAX-1:0]  shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 brk_q, brk_d;

  logic [DIV_WIDTH-1:0] div_clamped;
  logic                 at_full, at_half, par_en, par_x;
  logic [BW-1:0]        last_idx;
  logic                 frame_done;

  assign div_clamped = (divider_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divider_i;
  assign at_full     = (cnt_q == div_q - DIV_WIDTH'(1));
  assign at_half     = (cnt_q == (div_q >> 1) - DIV_WIDTH'(1));
  assign par_en      = (par_q == 2'b01) || (par_q == 2'b10);
  assign par_x       = (^shreg_q) ^ rxs;
  assign last_idx    = BW'(nbits_q) + BW'(4);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + DIV_WIDTH'(1);
    div_d      = div_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    brk_d      = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en_i && !rxs) begin
          state_d = S_START;
          div_d   = div_clamped;
          nbits_d = nbits_i;
          par_d   = parity_i;
          stop2_d = stop2_i;
          bidx_d  = '0;
          shreg_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          zero_d  = 1'b1;
        end
      end
      S_START: begin
        if (at_half) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_full) begin
          cnt_d  = '0;
          zero_d = zero_q & ~rxs;
          bidx_d = bidx_q + BW'(1);
          for (int unsigned i = 0; i < DATA_MAX; i++) begin
            if (BW'(i) == bidx_q) shreg_d[i] = rxs;
          end
          if (bidx_q == last_idx) state_d = par_en ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (at_full) begin
          cnt_d   = '0;
          zero_d  = zero_q & ~rxs;
          perr_d  = ((par_q == 2'b01) && par_x) || ((par_q == 2'b10) && !par_x);
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (at_full) begin
          cnt_d  = '0;
          zero_d = zero_q & ~rxs;
          ferr_d = ferr_q | ~rxs;
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
            brk_d      = zero_d;
          end
        end
      end
      S_STOP2: begin
        if (at_full) begin
          cnt_d      = '0;
          zero_d     = zero_q & ~rxs;
          ferr_d     = ferr_q | ~rxs;
          state_d    = S_IDLE;
          frame_done = 1'b1;
          brk_d      = zero_d;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides everything, including a frame finishing this cycle.
    if (!en_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      frame_done = 1'b0;
      brk_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(4);
      nbits_q <= '0;
      par_q   <= '0;
      stop2_q <= 1'b0;
      bidx_q  <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      brk_q   <= brk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcnt_q;
  logic          ovf_q;
  logic          full, pop, push, ovf_set;
  logic [EW-1:0] head;

  assign rvalid_o = (fcnt_q != '0);
  assign full     = (fcnt_q == FULL_CNT);
  assign pop      = rvalid_o & rready_i;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push     = frame_done & (~full | pop);
  assign ovf_set  = frame_done & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {shreg_q, perr_q, ferr_d};
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + (AW + 1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (AW + 1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (ovf_set)        ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
    end
  end

  assign head    = mem_q[rd_q];
  assign rdata_o = rvalid_o ? head[EW-1:2] : '0;
  assign perr_o  = rvalid_o & head[1];
  assign ferr_o  = rvalid_o & head[0];
  assign ovf_o   = ovf_q;
  assign break_o = brk_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_udm_uart_rx_cfg.sv
module tb_udm_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        srst_n, rx, en, stop2, rready, ovf_clr;
  logic [23:0] divider;
  logic [1:0]  nbits, parity;
  logic [7:0]  rdata;
  logic        perr, ferr, rvalid, ovf, brk, busy;

  int total = 0;
  int bad   = 0;
  int brk_cnt = 0;

  // current line configuration as seen by the bench
  int       cur_div = 16;
  int       cur_nb  = 8;
  logic [1:0] cur_pm = 2'b00;
  logic     cur_two = 1'b0;

  udm_uart_rx_cfg #(
    .DATA_MAX(8), .FIFO_DEPTH(4), .DIV_WIDTH(24), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .srst_n_i(srst_n), .rx_i(rx), .en_i(en),
    .divider_i(divider), .nbits_i(nbits), .parity_i(parity), .stop2_i(stop2),
    .rdata_o(rdata), .perr_o(perr), .ferr_o(ferr), .rvalid_o(rvalid),
    .rready_i(rready), .ovf_o(ovf), .ovf_clr_i(ovf_clr), .break_o(brk),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (brk === 1'b1) brk_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int div, input logic [1:0] nb, input logic [1:0] pm, input logic two);
    divider = 24'(div); nbits = nb; parity = pm; stop2 = two;
    cur_div = div; cur_nb = 5 + int'(nb); cur_pm = pm; cur_two = two;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cycles(cur_div);
  endtask

  function automatic logic [7:0] masked(input logic [7:0] d);
    logic [7:0] m;
    m = 8'((9'd1 << cur_nb) - 9'd1);
    return d & m;
  endfunction

  function automatic logic pen();
    return (cur_pm == 2'b01) || (cur_pm == 2'b10);
  endfunction

  // Parity bit actually put on the line: the correct one, inverted when flip=1.
  function automatic logic sent_pbit(input logic [7:0] d, input logic flip);
    int ones;
    logic [7:0] dm;
    dm = masked(d);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(dm[i]);
    if (cur_pm == 2'b01) return logic'(ones % 2) ^ flip;   // even: total ones even
    else                 return logic'((ones + 1) % 2) ^ flip;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic s1, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < cur_nb; i++) drive_bit(d[i]);
    if (pen()) drive_bit(sent_pbit(d, flip));
    drive_bit(s1);
    if (cur_two) drive_bit(s2);
    rx = 1'b1;
  endtask

  // Expected frame from the line-level description: {brk, data, perr, ferr}.
  function automatic logic [10:0] model(input logic [7:0] d, input logic flip, input logic s1, input logic s2);
    logic [7:0] dm;
    logic pe, fe, bk;
    dm = masked(d);
    pe = pen() && flip;
    fe = !s1 || (cur_two && !s2);
    bk = (dm == 8'h00) && (!pen() || !sent_pbit(d, flip)) && !s1 && (!cur_two || !s2);
    return {bk, dm, pe, fe};
  endfunction

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (rvalid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rvalid), 32'd1);
  endtask

  task automatic pop();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [10:0] e, input logic last);
    wait_valid({tag, "_valid"}, 6 * cur_div);
    check({tag, "_data"}, 32'(rdata), 32'(e[9:2]));
    check({tag, "_perr"}, 32'(perr), 32'(e[1]));
    check({tag, "_ferr"}, 32'(ferr), 32'(e[0]));
    pop();
    if (last) check({tag, "_empty"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [10:0] e;
    logic [10:0] q[$];
    logic [7:0]  d;
    logic        flip, s1, s2, ovf_exp;
    int          b0, brk_exp, k, n;

    srst_n = 1'b0; rx = 1'b1; en = 1'b1; rready = 1'b0; ovf_clr = 1'b0;
    set_cfg(16, 2'b11, 2'b00, 1'b0);
    cycles(3);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata",  32'(rdata),  32'd0);
    check("rst_perr",   32'(perr),   32'd0);
    check("rst_ferr",   32'(ferr),   32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_break",  32'(brk),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    srst_n = 1'b1;
    cycles(5);

    // 8N1 0x55
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    expect_head("t1", model(8'h55, 1'b0, 1'b1, 1'b1), 1'b1);
    check("t1_busy", 32'(busy), 32'd0);

    // 7E2: good, parity error, second stop bit low
    set_cfg(16, 2'b10, 2'b01, 1'b1);
    send_frame(8'h41, 1'b0, 1'b1, 1'b1); cycles(32);
    expect_head("e2_ok", 11'({1'b0, 8'h41, 1'b0, 1'b0}), 1'b1);
    send_frame(8'h41, 1'b1, 1'b1, 1'b1); cycles(32);
    expect_head("e2_perr", 11'({1'b0, 8'h41, 1'b1, 1'b0}), 1'b1);
    send_frame(8'h41, 1'b0, 1'b1, 1'b0); cycles(32);
    expect_head("e2_ferr", 11'({1'b0, 8'h41, 1'b0, 1'b1}), 1'b1);

    // false start: 4 low cycles
    set_cfg(16, 2'b11, 2'b00, 1'b0);
    rx = 1'b0; cycles(4); rx = 1'b1;
    cycles(1);
    check("fs_busy_hi", 32'(busy), 32'd1);
    cycles(20);
    check("fs_busy_lo", 32'(busy), 32'd0);
    check("fs_novalid", 32'(rvalid), 32'd0);

    // overflow: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b1);
    cycles(16);
    check("ovf_set", 32'(ovf), 32'd1);
    for (int i = 1; i <= 4; i++)
      expect_head("ovf_pop", model(8'(i), 1'b0, 1'b1, 1'b1), (i == 4));
    check("ovf_still", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; cycles(1); ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // break: line low for 12 bit times
    b0 = brk_cnt;
    rx = 1'b0; cycles(12 * cur_div); rx = 1'b1;
    expect_head("brk", 11'({1'b1, 8'h00, 1'b0, 1'b1}), 1'b0);
    // the still-low line re-arms the receiver; let that frame finish and drain it
    n = 0;
    while (busy === 1'b1 && n < 40 * cur_div) begin @(negedge clk); n++; end
    check("brk_idle", 32'(busy), 32'd0);
    cycles(2 * cur_div);
    n = 0;
    while (rvalid === 1'b1 && n < 8) begin pop(); n++; end
    check("brk_pulses", 32'(brk_cnt - b0), 32'd1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    expect_head("brk_after", model(8'h3C, 1'b0, 1'b1, 1'b1), 1'b1);

    // reset during data bit 3, with a frame already queued
    send_frame(8'h11, 1'b0, 1'b1, 1'b1); cycles(16);
    check("mr_pre_valid", 32'(rvalid), 32'd1);
    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3]; cycles(cur_div / 2);
    check("mr_pre_busy", 32'(busy), 32'd1);
    srst_n = 1'b0; rx = 1'b1; cycles(1); srst_n = 1'b1;
    check("mr_rvalid", 32'(rvalid), 32'd0);
    check("mr_busy",   32'(busy),   32'd0);
    check("mr_rdata",  32'(rdata),  32'd0);
    cycles(3 * cur_div);
    check("mr_nopush", 32'(rvalid), 32'd0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    expect_head("mr_after", model(8'hA5, 1'b0, 1'b1, 1'b1), 1'b1);

    // enable dropped mid-frame
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    en = 1'b0; rx = 1'b1; cycles(1);
    check("en_busy", 32'(busy), 32'd0);
    en = 1'b1; cycles(12 * cur_div);
    check("en_nopush", 32'(rvalid), 32'd0);

    // randomized bursts against a queue model of the FIFO
    for (int r = 0; r < 8; r++) begin
      set_cfg(int'($urandom_range(8, 20)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      k = int'($urandom_range(1, 6));
      q.delete(); ovf_exp = 1'b0; brk_exp = 0; b0 = brk_cnt;
      for (int j = 0; j < k; j++) begin
        d    = 8'($urandom);
        flip = ($urandom_range(0, 3) == 0);
        s1   = ($urandom_range(0, 3) != 0);
        s2   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) begin
          d = 8'h00; s1 = 1'b0; s2 = 1'b0; flip = (cur_pm == 2'b10);
        end
        send_frame(d, flip, s1, s2);
        cycles(2 * cur_div);
        e = model(d, flip, s1, s2);
        brk_exp += int'(e[10]);
        if (q.size() < 4) q.push_back(e);
        else              ovf_exp = 1'b1;
      end
      check("rnd_ovf", 32'(ovf), 32'(ovf_exp));
      check("rnd_brk", 32'(brk_cnt - b0), 32'(brk_exp));
      while (q.size() > 0) begin
        e = q.pop_front();
        expect_head("rnd", e, (q.size() == 0));
      end
      ovf_clr = 1'b1; cycles(1); ovf_clr = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
